wall_array_ctrl: RTL and testbench
==================================

// Module: wall_array_ctrl
// PURPOSE
//  Controls NUM_WALLS independent scrolling walls for the game datapath. Each wall runs
//  its own READY/MOVE/STOP FSM and owns an x-position counter. A spawn timer launches
//  free walls at fixed tick spacing. Any collision freezes the whole array until restart.
//  Sits between the frame-tick generator and the VGA draw/erase datapath and score logic.
// PARAMETERS
//  NUM_WALLS   4    number of wall lanes (1..8)
//  X_W         8    width of one x coordinate
//  X_START     159  x loaded when a wall is READY or spawned
//  X_END       0    a moving wall retires once its next x would be < X_END
//  STEP        1    pixels moved per tick
//  SPAWN_GAP   40   ticks between successive spawns (>=1)
//  PLAYER_X    20   x of the player column; crossing it scores
// PORTS
//  clk          in   1              system clock
//  resetn       in   1              reset; synchronous, active-low
//  start        in   1              1-cycle pulse: begin or restart game
//  tick         in   1              1-cycle frame enable; all motion happens on tick
//  touched      in   NUM_WALLS      per-wall collision flag from datapath
//  wall_x       out  NUM_WALLS*X_W  packed x positions, wall i at [i*X_W +: X_W]
//  wall_active  out  NUM_WALLS      1 = wall i in MOVE or STOP (draw it)
//  passed_cnt   out  clog2(NUM_WALLS+1)  walls crossing PLAYER_X this tick (1-cycle valid)
//  running      out  1              game state G_RUN
//  game_over    out  1              game state G_OVER (level, held)
// BEHAVIOUR
//  Reset: game state G_IDLE; all walls W_READY; every wall_x = X_START; wall_active = 0;
//   passed_cnt = 0; running = 0; game_over = 0; spawn counter = SPAWN_GAP-1.
//  Game FSM: G_IDLE -start-> G_RUN; G_RUN -any touched[i] with wall i in W_MOVE-> G_OVER;
//   G_OVER -start-> G_RUN. start in G_RUN is ignored. All outputs are registered.
//  On entry to G_RUN: all walls W_READY, x = X_START, spawn counter = SPAWN_GAP-1
//   (the first tick spawns immediately).
//  Per-wall FSM (encoding W_READY=2'b00, W_MOVE=2'b01, W_STOP=2'b11):
//   W_READY: x held at X_START; -> W_MOVE on launch (same tick, x unchanged that tick).
//   W_MOVE: on tick, if x-STEP < X_END (evaluated in X_W+1 bits, no wrap) -> W_READY,
//    x = X_START; else x <= x-STEP. Freeze -> W_STOP.
//   W_STOP: x held; wall_active = 1; -> W_READY only on restart (start in G_OVER).
//  Freeze: the cycle game enters G_OVER, every W_MOVE wall goes to W_STOP.
//   touched from W_READY walls is ignored.
//  Spawner (G_RUN only): on tick, if counter == SPAWN_GAP-1, launch the lowest-index
//   W_READY wall and clear counter to 0. If no wall is free, hold counter and retry each
//   tick. Otherwise counter increments on tick.
//  Scoring: passed_cnt = number of walls whose x goes from >= PLAYER_X to < PLAYER_X on
//   this tick. It is registered, valid 1 cycle after tick, and 0 on all other cycles.
//  Simultaneous events:
//   - touched and tick in the same cycle: touched wins; no motion, no spawn, no score.
//   - Retire and spawn on the same tick: the retired wall is not free until the next tick.
//   - start and touched in G_OVER: restart wins.
//  resetn low at any time, including mid-game, overrides everything in that cycle.
//  Between ticks, no state changes except freeze and restart.
// STRUCTURE
//  wall_pkg: W_READY/W_MOVE/W_STOP and G_IDLE/G_RUN/G_OVER encodings.
//  Sub-module wall_lane: one wall FSM plus x counter, with inputs launch, freeze,
//   restart and tick, and outputs x, active, crossed, free. It is instantiated
//   NUM_WALLS times via generate.
//  Top level holds the game FSM, spawn counter, lowest-free priority encoder and the
//   crossed popcount.
// TESTING
//  1 Reset then start, 3 ticks -> wall0 x=159,158,157 (launch tick holds 159);
//    walls1-3 inactive; running=1.
//  2 SPAWN_GAP=40, 41 ticks after start -> wall1 launched on tick 41;
//    wall0 x=119 at that point.
//  3 Run wall0 to x=20 then tick -> x=19; passed_cnt=1 for exactly one cycle.
//    At x=0, next tick -> wall0 W_READY, x=159, active=0.
//  4 All 4 walls moving, touched[2]=1 with tick -> game_over=1, no x changes,
//    all active walls W_STOP. Further ticks change nothing.
//  5 In G_OVER, start -> all W_READY, x=159, running=1, first tick spawns wall0.
//    touched from an inactive lane -> ignored.
//  6 resetn low mid-game for 1 cycle -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/wall_pkg.sv
// Shared state encodings for the scrolling-wall controller and its lanes.
package wall_pkg;

    typedef enum logic [1:0] {
        W_READY = 2'b00,
        W_MOVE  = 2'b01,
        W_STOP  = 2'b11
    } wall_state_t;

    typedef enum logic [1:0] {
        G_IDLE = 2'b00,
        G_RUN  = 2'b01,
        G_OVER = 2'b10
    } game_state_t;

endpackage

// File: rtl/wall_lane.sv
// One scrolling wall: READY/MOVE/STOP FSM plus its x-position counter.
module wall_lane
    import wall_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int X_START  = 159,
    parameter int X_END    = 0,
    parameter int STEP     = 1,
    parameter int PLAYER_X = 20
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           tick,
    input  logic           launch,
    input  logic           freeze,
    input  logic           restart,
    output logic [X_W-1:0] x,
    output logic           active,
    output logic           crossed,
    output logic           free
);

    // Thresholds are widened by one bit so "x - STEP" comparisons never wrap.
    localparam logic [X_W:0]   RETIRE_LIM = (X_W+1)'(X_END + STEP);
    localparam logic [X_W:0]   CROSS_LIM  = (X_W+1)'(PLAYER_X + STEP);
    localparam logic [X_W:0]   PLAYER     = (X_W+1)'(PLAYER_X);
    localparam logic [X_W-1:0] X_INIT     = X_W'(X_START);
    localparam logic [X_W-1:0] X_STEP     = X_W'(STEP);

    wall_state_t    state, state_next;
    logic [X_W-1:0] x_next;
    logic           retire;

    assign retire  = ({1'b0, x} < RETIRE_LIM);
    assign active  = (state != W_READY);
    assign free    = (state == W_READY);
    assign crossed = (state == W_MOVE) && !retire &&
                     ({1'b0, x} >= PLAYER) && ({1'b0, x} < CROSS_LIM);

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        x_next     = x;
        if (restart) begin
            state_next = W_READY;
            x_next     = X_INIT;
        end else if (freeze) begin
            if (state == W_MOVE) state_next = W_STOP;
        end else if (tick) begin
            case (state)
                W_READY: if (launch) state_next = W_MOVE;
                W_MOVE: begin
                    if (retire) begin
                        state_next = W_READY;
                        x_next     = X_INIT;
                    end else begin
                        x_next = x - X_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= W_READY;
            x     <= X_INIT;
        end else begin
            state <= state_next;
            x     <= x_next;
        end
    end

endmodule

// File: rtl/wall_array_ctrl.sv
// Game FSM, spawn timer and scoring around NUM_WALLS independent wall lanes.
module wall_array_ctrl
    import wall_pkg::*;
#(
    parameter int NUM_WALLS = 4,
    parameter int X_W       = 8,
    parameter int X_START   = 159,
    parameter int X_END     = 0,
    parameter int STEP      = 1,
    parameter int SPAWN_GAP = 40,
    parameter int PLAYER_X  = 20
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    input  logic                               tick,
    input  logic [NUM_WALLS-1:0]               touched,
    output logic [NUM_WALLS*X_W-1:0]           wall_x,
    output logic [NUM_WALLS-1:0]               wall_active,
    output logic [$clog2(NUM_WALLS+1)-1:0]     passed_cnt,
    output logic                               running,
    output logic                               game_over
);

    localparam int PW = $clog2(NUM_WALLS + 1);
    localparam int CW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_GAP - 1);

    game_state_t          g_state, g_next;
    logic [CW-1:0]        spawn_cnt, cnt_next;
    logic [NUM_WALLS-1:0] lane_active, lane_crossed, lane_free, launch;
    logic                 restart, hit, run_tick, spawn_due, taken;
    logic [PW-1:0]        pop;

    // STOP lanes only exist in G_OVER, so an active lane during G_RUN is a moving one.
    assign restart   = start && (g_state != G_RUN);
    assign hit       = (g_state == G_RUN) && |(touched & lane_active);
    assign run_tick  = (g_state == G_RUN) && tick && !hit;
    assign spawn_due = run_tick && (spawn_cnt == CNT_LAST);

    always_comb begin
        launch = '0;
        taken  = 1'b0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            if (spawn_due && lane_free[i] && !taken) begin
                launch[i] = 1'b1;
                taken     = 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_WALLS; i++) pop = pop + PW'(lane_crossed[i]);
    end

    always_comb begin
        cnt_next = spawn_cnt;
        if (restart) begin
            cnt_next = CNT_LAST;
        end else if (run_tick) begin
            if (spawn_cnt != CNT_LAST) cnt_next = spawn_cnt + 1'b1;
            else if (|lane_free)       cnt_next = '0;
        end
    end

    always_comb begin
        g_next = g_state;
        case (g_state)
            G_IDLE:  if (start) g_next = G_RUN;
            G_RUN:   if (hit)   g_next = G_OVER;
            G_OVER:  if (start) g_next = G_RUN;
            default: g_next = G_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            g_state    <= G_IDLE;
            spawn_cnt  <= CNT_LAST;
            passed_cnt <= '0;
            running    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            g_state    <= g_next;
            spawn_cnt  <= cnt_next;
            passed_cnt <= run_tick ? pop : '0;
            running    <= (g_next == G_RUN);
            game_over  <= (g_next == G_OVER);
        end
    end

    assign wall_active = lane_active;

    for (genvar i = 0; i < NUM_WALLS; i++) begin : g_lane
        wall_lane #(
            .X_W      (X_W),
            .X_START  (X_START),
            .X_END    (X_END),
            .STEP     (STEP),
            .PLAYER_X (PLAYER_X)
        ) u_lane (
            .clk     (clk),
            .resetn  (resetn),
            .tick    (run_tick),
            .launch  (launch[i]),
            .freeze  (hit),
            .restart (restart),
            .x       (wall_x[i*X_W +: X_W]),
            .active  (lane_active[i]),
            .crossed (lane_crossed[i]),
            .free    (lane_free[i])
        );
    end

endmodule

// File: tb/tb_wall_array_ctrl.sv
// Randomized scoreboard bench for wall_array_ctrl against a tick-level game model.
module tb_wall_array_ctrl;

    localparam int NW  = 4;
    localparam int XW  = 8;
    localparam int XS  = 159;
    localparam int XE  = 0;
    localparam int ST  = 1;
    localparam int GAP = 40;
    localparam int PX  = 20;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OVER = 2;

    logic             clk = 1'b0;
    logic             resetn, start, tick;
    logic [NW-1:0]    touched;
    logic [NW*XW-1:0] wall_x;
    logic [NW-1:0]    wall_active;
    logic [2:0]       passed_cnt;
    logic             running, game_over;

    wall_array_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .tick        (tick),
        .touched     (touched),
        .wall_x      (wall_x),
        .wall_active (wall_active),
        .passed_cnt  (passed_cnt),
        .running     (running),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW*XW-1:0] x;
        logic [NW-1:0]    act;
        logic [2:0]       pc;
        logic             run;
        logic             over;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   ncyc         = 0;

    // Reference model: one entry per wall, state advanced once per clock.
    int m_game;
    int m_x[NW];
    bit m_on[NW];
    bit m_stop[NW];
    int m_cnt;
    int m_pass;

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    function automatic void model_clear(input int game);
        m_game = game;
        m_cnt  = GAP - 1;
        for (int i = 0; i < NW; i++) begin
            m_x[i]    = XS;
            m_on[i]   = 1'b0;
            m_stop[i] = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit rn, input bit st, input bit tk, input logic [NW-1:0] tc);
        bit hit;
        bit was_free[NW];
        int nx;
        int pick;
        m_pass = 0;
        if (!rn) begin
            model_clear(M_IDLE);
        end else if (st && m_game != M_RUN) begin
            model_clear(M_RUN);
        end else if (m_game == M_RUN) begin
            hit = 1'b0;
            for (int i = 0; i < NW; i++) if (tc[i] && m_on[i]) hit = 1'b1;
            if (hit) begin
                m_game = M_OVER;
                for (int i = 0; i < NW; i++)
                    if (m_on[i]) begin
                        m_on[i]   = 1'b0;
                        m_stop[i] = 1'b1;
                    end
            end else if (tk) begin
                for (int i = 0; i < NW; i++) was_free[i] = !m_on[i] && !m_stop[i];
                for (int i = 0; i < NW; i++) begin
                    if (m_on[i]) begin
                        nx = m_x[i] - ST;
                        if (nx < XE) begin
                            m_on[i] = 1'b0;
                            m_x[i]  = XS;
                        end else begin
                            if (m_x[i] >= PX && nx < PX) m_pass++;
                            m_x[i] = nx;
                        end
                    end
                end
                if (m_cnt == GAP - 1) begin
                    pick = -1;
                    for (int i = 0; i < NW; i++) if (was_free[i] && pick < 0) pick = i;
                    if (pick >= 0) begin
                        m_on[pick] = 1'b1;
                        m_cnt      = 0;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    endfunction

    function automatic logic [NW-1:0] ready_mask();
        logic [NW-1:0] m;
        for (int i = 0; i < NW; i++) m[i] = !m_on[i] && !m_stop[i];
        return m;
    endfunction

    function automatic bit all_on();
        bit a = 1'b1;
        for (int i = 0; i < NW; i++) if (!m_on[i]) a = 1'b0;
        return a;
    endfunction

    function automatic logic [NW-1:0] rand_lanes();
        logic [NW-1:0] r;
        r = NW'($urandom);
        return r;
    endfunction

    // Drive one clock's inputs on the falling edge and queue the state expected after the next rising edge.
    task automatic cyc(input bit rn, input bit st, input bit tk, input logic [NW-1:0] tc);
        exp_t e;
        @(negedge clk);
        resetn  = rn;
        start   = st;
        tick    = tk;
        touched = tc;
        model_step(rn, st, tk, tc);
        for (int i = 0; i < NW; i++) begin
            e.x[i*XW +: XW] = XW'(m_x[i]);
            e.act[i]        = m_on[i] || m_stop[i];
        end
        e.pc   = 3'(m_pass);
        e.run  = (m_game == M_RUN);
        e.over = (m_game == M_OVER);
        e.cyc  = ncyc;
        ncyc++;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wall_x",      e.cyc, 32'(wall_x),      32'(e.x));
                check("wall_active", e.cyc, 32'(wall_active), 32'(e.act));
                check("passed_cnt",  e.cyc, 32'(passed_cnt),  32'(e.pc));
                check("running",     e.cyc, 32'(running),     32'(e.run));
                check("game_over",   e.cyc, 32'(game_over),   32'(e.over));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int hit_lane;
        resetn  = 1'b0;
        start   = 1'b0;
        tick    = 1'b0;
        touched = '0;

        repeat (3) cyc(0, 0, 1, '1);
        repeat (4) cyc(1, 0, 1, rand_lanes());
        cyc(1, 1, 0, '0);
        repeat (3) cyc(1, 0, 1, '0);

        // Long run: spawns, retires, crossings, ignored restarts and ignored touches on idle lanes.
        for (int n = 0; n < 800; n++)
            cyc(1, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 9) == 0) ? (rand_lanes() & ready_mask()) : '0);

        for (int k = 0; k < 200 && !all_on(); k++) cyc(1, 0, 1, '0);
        hit_lane = -1;
        if (m_on[2]) hit_lane = 2;
        for (int i = 0; i < NW; i++) if (hit_lane < 0 && m_on[i]) hit_lane = i;
        if (hit_lane < 0) hit_lane = 0;
        cyc(1, 0, 1, NW'(1) << hit_lane);
        for (int n = 0; n < 20; n++) cyc(1, 0, $urandom_range(0, 1) == 1, rand_lanes());

        cyc(1, 1, 1, '1);
        for (int n = 0; n < 200; n++)
            cyc(1, 0, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 7) == 0) ? (rand_lanes() & ready_mask()) : '0);

        cyc(0, 0, 1, '0);
        repeat (3) cyc(1, 0, 1, '0);
        cyc(1, 1, 1, '0);

        for (int n = 0; n < 600; n++)
            cyc(1, $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 39) == 0) ? rand_lanes() : '0);

        @(posedge clk);
        #2;
        check("scoreboard_drain", ncyc, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
